// File: rtl/ascon_pkg.sv
// Shared Ascon definitions: bdi/bdo segment types plus the arbiter's state,
// owner encoding and default statistics counter width.
package ascon_pkg;

  localparam int ASCON_STATS_W = 16;

  localparam logic [3:0] D_NULL  = 4'd0;
  localparam logic [3:0] D_NONCE = 4'd1;
  localparam logic [3:0] D_AD    = 4'd2;
  localparam logic [3:0] D_MSG   = 4'd3;
  localparam logic [3:0] D_TAG   = 4'd4;
  localparam logic [3:0] D_HASH  = 4'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_A = 1'b0,
    ARB_B = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/ascon_arb_rr.sv
// Combinational two-way round-robin picker: req[0] is client A, req[1] is
// client B; on a tie the client that did not own the core last time wins.
module ascon_arb_rr
  import ascon_pkg::*;
(
  input  logic [1:0] req,
  input  arb_owner_t last,
  output arb_owner_t gnt,
  output logic       gnt_valid
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the
    // if/else chain leaves it unassigned, which would infer a latch.
    gnt_valid = |req;
    gnt       = ARB_A;
    if (req == 2'b11) begin
      gnt = (last == ARB_A) ? ARB_B : ARB_A;
    end else if (req[1]) begin
      gnt = ARB_B;
    end
  end

endmodule

// File: rtl/ascon_arbiter.sv
// Two-client arbiter sharing one ascon_core for whole operations, round-robin.
// Define ASCON_ARB_STATS_EN to add saturating per-client completed-op counters.
module ascon_arbiter
  import ascon_pkg::*;
#(
  parameter int CCW     = 32,
  parameter int CCSW    = 32,
  parameter int STATS_W = ASCON_STATS_W
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic [CCSW-1:0]  a_key,
  input  logic             a_key_valid,
  output logic             a_key_ready,
  input  logic [CCW-1:0]   a_bdi,
  input  logic             a_bdi_valid,
  output logic             a_bdi_ready,
  input  logic [CCW/8-1:0] a_bdi_valid_bytes,
  input  logic [3:0]       a_bdi_type,
  input  logic             a_bdi_eot,
  input  logic             a_bdi_eoi,
  input  logic             a_decrypt,
  input  logic             a_hash,
  output logic [CCW-1:0]   a_bdo,
  output logic             a_bdo_valid,
  input  logic             a_bdo_ready,
  output logic [3:0]       a_bdo_type,
  output logic             a_bdo_eot,
  output logic             a_auth,
  output logic             a_auth_valid,
  output logic             a_done,

  input  logic [CCSW-1:0]  b_key,
  input  logic             b_key_valid,
  output logic             b_key_ready,
  input  logic [CCW-1:0]   b_bdi,
  input  logic             b_bdi_valid,
  output logic             b_bdi_ready,
  input  logic [CCW/8-1:0] b_bdi_valid_bytes,
  input  logic [3:0]       b_bdi_type,
  input  logic             b_bdi_eot,
  input  logic             b_bdi_eoi,
  input  logic             b_decrypt,
  input  logic             b_hash,
  output logic [CCW-1:0]   b_bdo,
  output logic             b_bdo_valid,
  input  logic             b_bdo_ready,
  output logic [3:0]       b_bdo_type,
  output logic             b_bdo_eot,
  output logic             b_auth,
  output logic             b_auth_valid,
  output logic             b_done,

  output logic             core_rst,
  output logic [CCSW-1:0]  core_key,
  output logic             core_key_valid,
  input  logic             core_key_ready,
  output logic [CCW-1:0]   core_bdi,
  output logic             core_bdi_valid,
  input  logic             core_bdi_ready,
  output logic [CCW/8-1:0] core_bdi_valid_bytes,
  output logic [3:0]       core_bdi_type,
  output logic             core_bdi_eot,
  output logic             core_bdi_eoi,
  output logic             core_decrypt,
  output logic             core_hash,
  input  logic [CCW-1:0]   core_bdo,
  input  logic             core_bdo_valid,
  output logic             core_bdo_ready,
  input  logic [3:0]       core_bdo_type,
  input  logic             core_bdo_eot,
  input  logic             core_auth,
  input  logic             core_auth_valid,
  input  logic             core_done
`ifdef ASCON_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0] ops_cnt_a,
  output logic [STATS_W-1:0] ops_cnt_b
`endif
);

  if (STATS_W < 1) begin : g_bad_stats_w
    $error("ascon_arbiter: STATS_W must be at least 1");
  end

  typedef struct packed {
    logic [CCSW-1:0]  key;
    logic             key_valid;
    logic [CCW-1:0]   bdi;
    logic             bdi_valid;
    logic [CCW/8-1:0] bdi_valid_bytes;
    logic [3:0]       bdi_type;
    logic             bdi_eot;
    logic             bdi_eoi;
    logic             decrypt;
    logic             hash;
    logic             bdo_ready;
  } cli_req_t;

  cli_req_t   a_req, b_req, sel_req;
  arb_state_t state;
  arb_owner_t owner, rr_last, pick;
  logic       pick_valid, core_done_q, done_rise;
  logic       busy, a_sel, b_sel;

  assign a_req = '{key: a_key, key_valid: a_key_valid, bdi: a_bdi, bdi_valid: a_bdi_valid,
                   bdi_valid_bytes: a_bdi_valid_bytes, bdi_type: a_bdi_type,
                   bdi_eot: a_bdi_eot, bdi_eoi: a_bdi_eoi, decrypt: a_decrypt,
                   hash: a_hash, bdo_ready: a_bdo_ready};
  assign b_req = '{key: b_key, key_valid: b_key_valid, bdi: b_bdi, bdi_valid: b_bdi_valid,
                   bdi_valid_bytes: b_bdi_valid_bytes, bdi_type: b_bdi_type,
                   bdi_eot: b_bdi_eot, bdi_eoi: b_bdi_eoi, decrypt: b_decrypt,
                   hash: b_hash, bdo_ready: b_bdo_ready};

  ascon_arb_rr u_rr (
    .req       ({b_req.key_valid | b_req.bdi_valid, a_req.key_valid | a_req.bdi_valid}),
    .last      (rr_last),
    .gnt       (pick),
    .gnt_valid (pick_valid)
  );

  assign busy      = (state == BUSY);
  assign a_sel     = busy && (owner == ARB_A);
  assign b_sel     = busy && (owner == ARB_B);
  assign done_rise = core_done & ~core_done_q;
  assign sel_req   = (owner == ARB_B) ? b_req : a_req;

  // The core is reset together with the arbiter so an abandoned op cannot linger.
  assign core_rst             = ~rst_n;
  assign core_key             = sel_req.key;
  assign core_key_valid       = busy & sel_req.key_valid;
  assign core_bdi             = sel_req.bdi;
  assign core_bdi_valid       = busy & sel_req.bdi_valid;
  assign core_bdi_valid_bytes = sel_req.bdi_valid_bytes;
  assign core_bdi_type        = sel_req.bdi_type;
  assign core_bdi_eot         = sel_req.bdi_eot;
  assign core_bdi_eoi         = sel_req.bdi_eoi;
  assign core_decrypt         = sel_req.decrypt;
  assign core_hash            = sel_req.hash;
  assign core_bdo_ready       = busy & sel_req.bdo_ready;

  assign a_key_ready = a_sel & core_key_ready;
  assign a_bdi_ready = a_sel & core_bdi_ready;
  assign a_bdo       = a_sel ? core_bdo : '0;
  assign a_bdo_valid = a_sel & core_bdo_valid;
  assign a_bdo_type  = a_sel ? core_bdo_type : '0;
  assign a_bdo_eot   = a_sel & core_bdo_eot;

  assign b_key_ready = b_sel & core_key_ready;
  assign b_bdi_ready = b_sel & core_bdi_ready;
  assign b_bdo       = b_sel ? core_bdo : '0;
  assign b_bdo_valid = b_sel & core_bdo_valid;
  assign b_bdo_type  = b_sel ? core_bdo_type : '0;
  assign b_bdo_eot   = b_sel & core_bdo_eot;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= ARB_A;
      rr_last      <= ARB_B;
      core_done_q  <= 1'b0;
      a_done       <= 1'b0;
      b_done       <= 1'b0;
      a_auth       <= 1'b0;
      a_auth_valid <= 1'b0;
      b_auth       <= 1'b0;
      b_auth_valid <= 1'b0;
    end else begin
      core_done_q <= core_done;
      a_done      <= 1'b0;
      b_done      <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner <= pick;
            state <= BUSY;
            if (pick == ARB_A) a_auth_valid <= 1'b0;
            else               b_auth_valid <= 1'b0;
          end
        end
        BUSY: begin
          // Only a fresh rising edge ends the op; a done left high by the
          // previous operation is ignored.
          if (done_rise) begin
            state   <= RELEASE;
            rr_last <= owner;
            if (owner == ARB_A) begin
              a_done <= 1'b1;
              if (core_auth_valid) begin
                a_auth       <= core_auth;
                a_auth_valid <= 1'b1;
              end
            end else begin
              b_done <= 1'b1;
              if (core_auth_valid) begin
                b_auth       <= core_auth;
                b_auth_valid <= 1'b1;
              end
            end
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ASCON_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_cnt_a <= '0;
      ops_cnt_b <= '0;
    end else if (busy && done_rise) begin
      if (owner == ARB_A && !(&ops_cnt_a)) ops_cnt_a <= ops_cnt_a + 1'b1;
      if (owner == ARB_B && !(&ops_cnt_b)) ops_cnt_b <= ops_cnt_b + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ascon_arbiter.sv
// Directed bench for ascon_arbiter; the bench itself plays the ascon_core side.
module tb_ascon_arbiter;
  import ascon_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] a_key, b_key, a_bdi, b_bdi, a_bdo, b_bdo;
  logic a_key_valid, a_key_ready, a_bdi_valid, a_bdi_ready, a_bdi_eot, a_bdi_eoi;
  logic b_key_valid, b_key_ready, b_bdi_valid, b_bdi_ready, b_bdi_eot, b_bdi_eoi;
  logic [3:0] a_bdi_valid_bytes, b_bdi_valid_bytes, a_bdi_type, b_bdi_type;
  logic [3:0] a_bdo_type, b_bdo_type;
  logic a_decrypt, a_hash, a_bdo_valid, a_bdo_ready, a_bdo_eot, a_auth, a_auth_valid, a_done;
  logic b_decrypt, b_hash, b_bdo_valid, b_bdo_ready, b_bdo_eot, b_auth, b_auth_valid, b_done;

  logic        core_rst, core_key_valid, core_key_ready, core_bdi_valid, core_bdi_ready;
  logic [31:0] core_key, core_bdi, core_bdo;
  logic [3:0]  core_bdi_valid_bytes, core_bdi_type, core_bdo_type;
  logic        core_bdi_eot, core_bdi_eoi, core_decrypt, core_hash;
  logic        core_bdo_valid, core_bdo_ready, core_bdo_eot, core_auth, core_auth_valid, core_done;
`ifdef ASCON_ARB_STATS_EN
  logic [1:0]  ops_cnt_a, ops_cnt_b;
`endif

  ascon_arbiter #(.CCW(32), .CCSW(32), .STATS_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_key(a_key), .a_key_valid(a_key_valid), .a_key_ready(a_key_ready),
    .a_bdi(a_bdi), .a_bdi_valid(a_bdi_valid), .a_bdi_ready(a_bdi_ready),
    .a_bdi_valid_bytes(a_bdi_valid_bytes), .a_bdi_type(a_bdi_type),
    .a_bdi_eot(a_bdi_eot), .a_bdi_eoi(a_bdi_eoi), .a_decrypt(a_decrypt), .a_hash(a_hash),
    .a_bdo(a_bdo), .a_bdo_valid(a_bdo_valid), .a_bdo_ready(a_bdo_ready),
    .a_bdo_type(a_bdo_type), .a_bdo_eot(a_bdo_eot),
    .a_auth(a_auth), .a_auth_valid(a_auth_valid), .a_done(a_done),
    .b_key(b_key), .b_key_valid(b_key_valid), .b_key_ready(b_key_ready),
    .b_bdi(b_bdi), .b_bdi_valid(b_bdi_valid), .b_bdi_ready(b_bdi_ready),
    .b_bdi_valid_bytes(b_bdi_valid_bytes), .b_bdi_type(b_bdi_type),
    .b_bdi_eot(b_bdi_eot), .b_bdi_eoi(b_bdi_eoi), .b_decrypt(b_decrypt), .b_hash(b_hash),
    .b_bdo(b_bdo), .b_bdo_valid(b_bdo_valid), .b_bdo_ready(b_bdo_ready),
    .b_bdo_type(b_bdo_type), .b_bdo_eot(b_bdo_eot),
    .b_auth(b_auth), .b_auth_valid(b_auth_valid), .b_done(b_done),
    .core_rst(core_rst), .core_key(core_key), .core_key_valid(core_key_valid),
    .core_key_ready(core_key_ready), .core_bdi(core_bdi), .core_bdi_valid(core_bdi_valid),
    .core_bdi_ready(core_bdi_ready), .core_bdi_valid_bytes(core_bdi_valid_bytes),
    .core_bdi_type(core_bdi_type), .core_bdi_eot(core_bdi_eot), .core_bdi_eoi(core_bdi_eoi),
    .core_decrypt(core_decrypt), .core_hash(core_hash), .core_bdo(core_bdo),
    .core_bdo_valid(core_bdo_valid), .core_bdo_ready(core_bdo_ready),
    .core_bdo_type(core_bdo_type), .core_bdo_eot(core_bdo_eot),
    .core_auth(core_auth), .core_auth_valid(core_auth_valid), .core_done(core_done)
`ifdef ASCON_ARB_STATS_EN
    , .ops_cnt_a(ops_cnt_a), .ops_cnt_b(ops_cnt_b)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int a_done_seen = 0;
  int b_done_seen = 0;

  always @(posedge clk) begin
    if (a_done === 1'b1) a_done_seen++;
    if (b_done === 1'b1) b_done_seen++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    {a_key, a_key_valid, a_bdi, a_bdi_valid, a_bdi_valid_bytes, a_bdi_type} = '0;
    {a_bdi_eot, a_bdi_eoi, a_decrypt, a_hash, a_bdo_ready} = '0;
    {b_key, b_key_valid, b_bdi, b_bdi_valid, b_bdi_valid_bytes, b_bdi_type} = '0;
    {b_bdi_eot, b_bdi_eoi, b_decrypt, b_hash, b_bdo_ready} = '0;
    {core_key_ready, core_bdi_ready, core_bdo, core_bdo_valid, core_bdo_type} = '0;
    {core_bdo_eot, core_auth, core_auth_valid, core_done} = '0;
  endtask

  // One minimal A operation starting from IDLE: grant, done edge, release.
  task automatic run_a_op();
    cyc(); a_key_valid = 1'b1;
    cyc(); a_key_valid = 1'b0; core_done = 1'b1;
    cyc(); core_done = 1'b0;
    cyc();
  endtask

  logic [31:0] key_w [4] = '{32'h0001_0203, 32'h0405_0607, 32'h0809_0A0B, 32'h0C0D_0E0F};
  logic [3:0]  bdi_t [7] = '{D_NONCE, D_NONCE, D_NONCE, D_NONCE, D_AD, D_MSG, D_MSG};

  initial begin
    idle_inputs();
    #1 rst_n = 1'b0;
    #2;
    core_key_ready = 1'b1; core_bdi_ready = 1'b1; core_bdo_valid = 1'b1;
    a_key_valid = 1'b1; b_bdi_valid = 1'b1; a_bdo_ready = 1'b1;
    #1;
    check("rst_core_rst", core_rst, 1);
    check("rst_core_key_valid", core_key_valid, 0);
    check("rst_core_bdo_ready", core_bdo_ready, 0);
    check("rst_a_key_ready", a_key_ready, 0);
    check("rst_b_bdi_ready", b_bdi_ready, 0);
    check("rst_a_bdo_valid", a_bdo_valid, 0);
    check("rst_a_done", a_done, 0);
    check("rst_a_auth_valid", a_auth_valid, 0);
    idle_inputs();
    cyc(); cyc(); rst_n = 1'b1;

    // A alone: AEAD encrypt, key, nonce, 1 AD word, 2 PT words
    cyc(); a_key_valid = 1'b1; a_key = key_w[0]; core_key_ready = 1'b1; settle();
    check("t1_idle_core_key_valid", core_key_valid, 0);
    check("t1_idle_a_key_ready", a_key_ready, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(); a_key = key_w[i]; settle();
      check("t1_core_key", core_key, key_w[i]);
      check("t1_core_key_valid", core_key_valid, 1);
      check("t1_a_key_ready", a_key_ready, 1);
      check("t1_b_key_ready", b_key_ready, 0);
    end
    for (int i = 0; i < 7; i++) begin
      cyc();
      a_key_valid = 1'b0; core_key_ready = 1'b0; core_bdi_ready = 1'b1;
      a_bdi_valid = 1'b1; a_bdi = 32'hB000_0000 + i; a_bdi_type = bdi_t[i];
      a_bdi_eot = (i == 3 || i == 4 || i == 6); a_bdi_eoi = (i == 6);
      settle();
      check("t1_core_bdi", core_bdi, 32'hB000_0000 + i);
      check("t1_core_bdi_type", core_bdi_type, bdi_t[i]);
      check("t1_core_bdi_eot", core_bdi_eot, (i == 3 || i == 4 || i == 6));
      check("t1_a_bdi_ready", a_bdi_ready, 1);
      check("t1_b_bdi_ready", b_bdi_ready, 0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      a_bdi_valid = 1'b0; a_bdi_eot = 1'b0; a_bdi_eoi = 1'b0; core_bdi_ready = 1'b0;
      core_bdo_valid = 1'b1; core_bdo = 32'hC000_0000 + i;
      core_bdo_type = (i == 2) ? D_TAG : D_MSG; core_bdo_eot = (i >= 1);
      a_bdo_ready = 1'b1; b_bdo_ready = 1'b1;
      settle();
      check("t1_a_bdo", a_bdo, 32'hC000_0000 + i);
      check("t1_a_bdo_valid", a_bdo_valid, 1);
      check("t1_a_bdo_type", a_bdo_type, (i == 2) ? 4'd4 : 4'd3);
      check("t1_a_bdo_eot", a_bdo_eot, (i >= 1));
      check("t1_core_bdo_ready", core_bdo_ready, 1);
      check("t1_b_bdo_valid", b_bdo_valid, 0);
      check("t1_b_bdo", b_bdo, 0);
    end
    cyc();
    core_bdo_valid = 1'b0; core_bdo_eot = 1'b0; a_bdo_ready = 1'b0; b_bdo_ready = 1'b0;
    core_done = 1'b1; settle();
    check("t1_done_not_yet", a_done, 0);
    cyc(); settle();
    check("t1_a_done_pulse", a_done, 1);
    check("t1_b_done", b_done, 0);
    check("t1_release_bdo_ready", core_bdo_ready, 0);
    check("t1_a_auth_valid_enc", a_auth_valid, 0);
    cyc(); settle();
    check("t1_a_done_low", a_done, 0);
    cyc(); cyc(); settle();
    check("t1_a_done_once", a_done_seen, 1);

    // Reset, then a tie with a stale done still high
    rst_n = 1'b0; #1;
    idle_inputs(); core_done = 1'b1;
    cyc(); rst_n = 1'b1;
    cyc();
    a_key_valid = 1'b1; a_key = 32'hAAAA_0001; b_key_valid = 1'b1; b_key = 32'hBBBB_0001;
    core_key_ready = 1'b1;
    cyc(); settle();
    check("t2_tie_a_first", core_key, 32'hAAAA_0001);
    check("t2_tie_a_key_ready", a_key_ready, 1);
    check("t2_tie_b_key_ready", b_key_ready, 0);
    cyc(); cyc(); settle();
    check("t2_stale_done_busy", core_key_valid, 1);
    check("t2_stale_done_no_pulse", a_done, 0);
    cyc(); core_done = 1'b0; a_key_valid = 1'b0;
    cyc(); core_done = 1'b1; settle();
    check("t2_edge_b_key_ready", b_key_ready, 0);
    cyc(); core_done = 1'b0; settle();
    check("t2_m1_a_done", a_done, 1);
    check("t2_m1_core_key_valid", core_key_valid, 0);
    cyc(); settle();
    check("t2_m2_core_key_valid", core_key_valid, 0);
    check("t2_m2_b_key_ready", b_key_ready, 0);
    cyc(); settle();
    check("t2_m3_core_key_valid", core_key_valid, 1);
    check("t2_m3_core_key", core_key, 32'hBBBB_0001);
    check("t2_m3_b_key_ready", b_key_ready, 1);
    check("t2_m3_a_key_ready", a_key_ready, 0);
    cyc(); b_key_valid = 1'b0; core_key_ready = 1'b0;
    cyc(); core_done = 1'b1;
    cyc(); core_done = 1'b0; settle();
    check("t2_b_done", b_done, 1);
    check("t2_b_auth_valid", b_auth_valid, 0);
    cyc();

    // A decrypt with a corrupted tag
    cyc();
    a_bdi_valid = 1'b1; a_decrypt = 1'b1; a_bdi_type = D_TAG; a_bdi = 32'hDEAD_BEEF;
    core_bdi_ready = 1'b1;
    cyc(); settle();
    check("t3_core_decrypt", core_decrypt, 1);
    check("t3_core_bdi_valid", core_bdi_valid, 1);
    check("t3_a_bdi_ready", a_bdi_ready, 1);
    cyc();
    a_bdi_valid = 1'b0; a_decrypt = 1'b0; core_bdi_ready = 1'b0;
    core_done = 1'b1; core_auth_valid = 1'b1; core_auth = 1'b0;
    cyc(); core_done = 1'b0; core_auth_valid = 1'b0; core_auth = 1'b1; settle();
    check("t3_a_done", a_done, 1);
    check("t3_a_auth_valid", a_auth_valid, 1);
    check("t3_a_auth", a_auth, 0);
    check("t3_b_auth_valid", b_auth_valid, 0);
    cyc();

    // B hash of one message word; A's auth result must survive it
    cyc();
    b_bdi_valid = 1'b1; b_hash = 1'b1; b_bdi = 32'h1234_5678; b_bdi_type = D_MSG;
    b_bdi_eot = 1'b1; b_bdi_eoi = 1'b1; core_bdi_ready = 1'b1; a_bdo_ready = 1'b1;
    cyc(); settle();
    check("t4_core_hash", core_hash, 1);
    check("t4_core_bdi_eoi", core_bdi_eoi, 1);
    check("t4_core_bdi", core_bdi, 32'h1234_5678);
    check("t4_b_bdi_ready", b_bdi_ready, 1);
    check("t4_a_bdi_ready", a_bdi_ready, 0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      b_bdi_valid = 1'b0; b_bdi_eot = 1'b0; b_bdi_eoi = 1'b0; core_bdi_ready = 1'b0;
      core_bdo_valid = 1'b1; core_bdo = 32'hA500_0000 + i; core_bdo_type = D_HASH;
      core_bdo_eot = (i == 7); b_bdo_ready = (i != 0);
      settle();
      check("t4_b_bdo", b_bdo, 32'hA500_0000 + i);
      check("t4_b_bdo_type", b_bdo_type, 4'd5);
      check("t4_b_bdo_eot", b_bdo_eot, (i == 7));
      check("t4_core_bdo_ready", core_bdo_ready, (i != 0));
      check("t4_a_bdo_valid", a_bdo_valid, 0);
    end
    cyc();
    core_bdo_valid = 1'b0; core_bdo_eot = 1'b0; b_hash = 1'b0; b_bdo_ready = 1'b0;
    a_bdo_ready = 1'b0; core_done = 1'b1;
    cyc(); core_done = 1'b0; settle();
    check("t4_b_done", b_done, 1);
    check("t4_a_auth_valid_held", a_auth_valid, 1);
    check("t4_a_auth_held", a_auth, 0);
    check("t4_b_auth_valid", b_auth_valid, 0);
    cyc();

    // A re-granted: its auth result is cleared
    cyc(); a_key_valid = 1'b1; settle();
    check("t3b_auth_valid_before_grant", a_auth_valid, 1);
    cyc(); settle();
    check("t3b_auth_valid_cleared", a_auth_valid, 0);
    check("t3b_core_key_valid", core_key_valid, 1);
    cyc(); a_key_valid = 1'b0; core_done = 1'b1;
    cyc(); core_done = 1'b0;
    cyc();

    // Reset in the middle of a B operation
    cyc(); b_bdi_valid = 1'b1; core_bdi_ready = 1'b1;
    cyc(); core_bdo_valid = 1'b1; core_bdo = 32'h0000_0055; b_bdo_ready = 1'b1; settle();
    check("t5_b_bdo_valid_busy", b_bdo_valid, 1);
    check("t5_b_bdi_ready_busy", b_bdi_ready, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_b_bdo_valid", b_bdo_valid, 0);
    check("t5_rst_b_bdo", b_bdo, 0);
    check("t5_rst_b_bdi_ready", b_bdi_ready, 0);
    check("t5_rst_core_bdi_valid", core_bdi_valid, 0);
    check("t5_rst_core_bdo_ready", core_bdo_ready, 0);
    check("t5_rst_core_rst", core_rst, 1);
    idle_inputs();
    cyc(); rst_n = 1'b1;
    cyc();
    a_key_valid = 1'b1; a_key = 32'hAAAA_0002; b_key_valid = 1'b1; b_key = 32'hBBBB_0002;
    cyc(); settle();
    check("t5_tie_a_wins", core_key, 32'hAAAA_0002);
    check("t5_tie_core_key_valid", core_key_valid, 1);
    cyc(); a_key_valid = 1'b0; b_key_valid = 1'b0; core_done = 1'b1;
    cyc(); core_done = 1'b0;
    cyc();

    // Four more A-only ops after the reset: five A ops in total
    for (int i = 0; i < 4; i++) run_a_op();
    cyc(); cyc();
`ifdef ASCON_ARB_STATS_EN
    check("t6_ops_cnt_a_sat", ops_cnt_a, 3);
    check("t6_ops_cnt_b", ops_cnt_b, 0);
`endif
    check("t6_a_done_total", a_done_seen, 9);
    check("t6_b_done_total", b_done_seen, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
